// File: rtl/alu_ctrl_decode_rv32i_pkg.sv
// Shared RV32I opcode constants and ALU control encodings, used by this decode
// stage and by the execute-stage ALU.
package alu_ctrl_decode_rv32i_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  typedef enum logic [1:0] {ALU_ADD = 2'b00, ALU_GATE = 2'b01, ALU_SHIFT = 2'b10, ALU_SLT = 2'b11} alutype_e;
  typedef enum logic [1:0] {GA_AND = 2'b00, GA_OR = 2'b01, GA_XOR = 2'b10} gatype_e;
  typedef enum logic [1:0] {SH_SLL = 2'b00, SH_SRL = 2'b01, SH_SRA = 2'b10} shiftype_e;
  typedef enum logic [1:0] {IN1_RS1 = 2'b00, IN1_PC = 2'b01, IN1_ZERO = 2'b10} in1sel_e;
  typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_e;

  typedef struct packed {
    alutype_e  alutype;
    logic      adtype;
    gatype_e   gatype;
    shiftype_e shiftype;
    logic      sltype;
    in1sel_e   in1sel;
    logic      in2sel;
    logic      regwrite;
    logic      illegal;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
  } ctrl_t;

  // funct3 -> ALU operation; alt selects SUB or SRA
  function automatic ctrl_t alu_map(ctrl_t c_in, logic [2:0] f3, logic alt);
    ctrl_t c;
    c = c_in;
    case (f3)
      3'b000:  begin c.alutype = ALU_ADD;   c.adtype   = alt;    end
      3'b111:  begin c.alutype = ALU_GATE;  c.gatype   = GA_AND; end
      3'b110:  begin c.alutype = ALU_GATE;  c.gatype   = GA_OR;  end
      3'b100:  begin c.alutype = ALU_GATE;  c.gatype   = GA_XOR; end
      3'b001:  begin c.alutype = ALU_SHIFT; c.shiftype = SH_SLL; end
      3'b101:  begin c.alutype = ALU_SHIFT; c.shiftype = alt ? SH_SRA : SH_SRL; end
      3'b010:  begin c.alutype = ALU_SLT;   c.sltype   = 1'b0;   end
      3'b011:  begin c.alutype = ALU_SLT;   c.sltype   = 1'b1;   end
      default: begin c.illegal = 1'b1; end
    endcase
    return c;
  endfunction

endpackage

// File: rtl/alu_ctrl_decode_rv32i_imm_gen.sv
// Immediate generator: selects the I/S/B/U/J immediate from the opcode.
// Shift-immediates return the zero-extended shamt.
module imm_gen_rv32i
  import alu_ctrl_decode_rv32i_pkg::*;
(
  input  logic [31:0] i_instr,
  output logic [31:0] o_imm
);

  logic [6:0] w_opc;
  logic       w_sgn;

  assign w_opc = i_instr[6:0];
  assign w_sgn = i_instr[31];

  // format select by opcode
  always_comb begin
    o_imm = 32'h0000_0000;
    case (w_opc)
      OPC_OPIMM: begin
        if (i_instr[13:12] == 2'b01) begin
          o_imm = {27'd0, i_instr[24:20]};
        end else begin
          o_imm = {{20{w_sgn}}, i_instr[31:20]};
        end
      end
      OPC_LOAD, OPC_JALR: o_imm = {{20{w_sgn}}, i_instr[31:20]};
      OPC_STORE:          o_imm = {{20{w_sgn}}, i_instr[31:25], i_instr[11:7]};
      OPC_BRANCH:         o_imm = {{19{w_sgn}}, i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC: o_imm = {i_instr[31:12], 12'h000};
      OPC_JAL:            o_imm = {{11{w_sgn}}, i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};
      default:            o_imm = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/alu_ctrl_decode_rv32i.sv
// Registered RV32I decode stage: one-entry valid/ready pipeline register that
// drives the ALU control fields, operand selects, register addresses and immediate.
module alu_ctrl_decode_rv32i
  import alu_ctrl_decode_rv32i_pkg::*;
#(
  parameter int          XLEN     = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
)(
  input  logic            clock,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [XLEN-1:0] out_imm,
  output logic [1:0]      cu_ALUtype,
  output logic            cu_adtype,
  output logic [1:0]      cu_gatype,
  output logic [1:0]      cu_shiftype,
  output logic            cu_sltype,
  output logic [1:0]      out_in1sel,
  output logic            out_in2sel,
  output logic            out_regwrite,
  output logic            out_illegal
);

  state_e          r_state;
  ctrl_t           r_ctrl;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_imm;

  ctrl_t      w_ctrl;
  logic [31:0] w_imm;
  logic [6:0] w_opc;
  logic [6:0] w_f7;
  logic [2:0] w_f3;
  logic       w_wr;
  logic       w_bad;
  logic       w_accept;

  assign w_opc = in_instr[6:0];
  assign w_f3  = in_instr[14:12];
  assign w_f7  = in_instr[31:25];

  imm_gen_rv32i u_imm_gen (
    .i_instr (in_instr),
    .o_imm   (w_imm)
  );

  // opcode/funct decode into control fields; illegal encodings zero everything but the flag
  always_comb begin
    w_ctrl     = '0;
    w_wr       = 1'b0;
    w_bad      = 1'b0;
    w_ctrl.rs1 = in_instr[19:15];
    w_ctrl.rs2 = in_instr[24:20];
    w_ctrl.rd  = in_instr[11:7];
    case (w_opc)
      OPC_OP: begin
        w_ctrl = alu_map(w_ctrl, w_f3, in_instr[30]);
        w_wr   = 1'b1;
        w_bad  = !((w_f7 == 7'b0000000) || ((w_f7 == F7_ALT) && ((w_f3 == 3'b000) || (w_f3 == 3'b101))));
      end
      OPC_OPIMM: begin
        w_ctrl        = alu_map(w_ctrl, w_f3, (w_f3 == 3'b101) && in_instr[30]);
        w_ctrl.in2sel = 1'b1;
        w_ctrl.rs2    = 5'd0;
        w_wr          = 1'b1;
        if (w_f3 == 3'b001) begin
          w_bad = (w_f7 != 7'b0000000);
        end else if (w_f3 == 3'b101) begin
          w_bad = (w_f7 != 7'b0000000) && (w_f7 != F7_ALT);
        end else begin
          w_bad = 1'b0;
        end
      end
      OPC_LUI, OPC_AUIPC, OPC_JAL: begin
        w_ctrl.in1sel = (w_opc == OPC_LUI) ? IN1_ZERO : IN1_PC;
        w_ctrl.in2sel = 1'b1;
        w_ctrl.rs1    = 5'd0;
        w_ctrl.rs2    = 5'd0;
        w_wr          = 1'b1;
      end
      OPC_JALR, OPC_LOAD: begin
        w_ctrl.in2sel = 1'b1;
        w_ctrl.rs2    = 5'd0;
        w_wr          = 1'b1;
      end
      OPC_STORE, OPC_BRANCH: begin
        w_ctrl.in1sel = (w_opc == OPC_BRANCH) ? IN1_PC : IN1_RS1;
        w_ctrl.in2sel = 1'b1;
        w_ctrl.rd     = 5'd0;
      end
      default: w_bad = 1'b1;
    endcase
    if (w_bad) begin
      w_ctrl         = '0;
      w_ctrl.illegal = 1'b1;
    end else begin
      w_ctrl.regwrite = w_wr && (w_ctrl.rd != 5'd0);
    end
  end

  assign in_ready = (r_state == ST_EMPTY) || out_ready;
  assign w_accept = in_valid && in_ready && !flush;

  // entry FSM and pipeline register; flush outranks a same-cycle accept
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_EMPTY;
      r_pc    <= RESET_PC;
      r_imm   <= '0;
      r_ctrl  <= '0;
    end else if (flush) begin
      r_state <= ST_EMPTY;
    end else if (w_accept) begin
      r_state <= ST_FULL;
      r_pc    <= in_pc;
      r_imm   <= w_imm;
      r_ctrl  <= w_ctrl;
    end else if (out_ready) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= r_state;
    end
  end

  assign out_valid    = (r_state == ST_FULL);
  assign out_pc       = r_pc;
  assign out_imm      = r_imm;
  assign out_rs1      = r_ctrl.rs1;
  assign out_rs2      = r_ctrl.rs2;
  assign out_rd       = r_ctrl.rd;
  assign cu_ALUtype   = r_ctrl.alutype;
  assign cu_adtype    = r_ctrl.adtype;
  assign cu_gatype    = r_ctrl.gatype;
  assign cu_shiftype  = r_ctrl.shiftype;
  assign cu_sltype    = r_ctrl.sltype;
  assign out_in1sel   = r_ctrl.in1sel;
  assign out_in2sel   = r_ctrl.in2sel;
  assign out_regwrite = r_ctrl.regwrite;
  assign out_illegal  = r_ctrl.illegal;

endmodule

// File: tb/tb_alu_ctrl_decode_rv32i.sv
// Directed self-checking bench for the RV32I decode stage.
module tb_alu_ctrl_decode_rv32i;

  logic        clock;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic [31:0] out_imm;
  logic [1:0]  cu_ALUtype, cu_gatype, cu_shiftype, out_in1sel;
  logic        cu_adtype, cu_sltype, out_in2sel, out_regwrite, out_illegal;

  int n_cmp = 0;
  int n_mis = 0;

  alu_ctrl_decode_rv32i #(.XLEN(32), .RESET_PC(32'h0000_0100)) dut (
    .clock(clock), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_pc(out_pc), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_rd(out_rd), .out_imm(out_imm), .cu_ALUtype(cu_ALUtype), .cu_adtype(cu_adtype),
    .cu_gatype(cu_gatype), .cu_shiftype(cu_shiftype), .cu_sltype(cu_sltype),
    .out_in1sel(out_in1sel), .out_in2sel(out_in2sel), .out_regwrite(out_regwrite),
    .out_illegal(out_illegal)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // control bundle {ALUtype,adtype,gatype,shiftype,sltype,in1sel,in2sel,regwrite,illegal}
  function automatic logic [31:0] obs_ctrl();
    return {19'd0, cu_ALUtype, cu_adtype, cu_gatype, cu_shiftype, cu_sltype,
            out_in1sel, out_in2sel, out_regwrite, out_illegal};
  endfunction

  function automatic logic [31:0] mk(input logic [1:0] alu, input logic ad, input logic [1:0] ga,
                                     input logic [1:0] sh, input logic sl, input logic [1:0] in1,
                                     input logic in2, input logic rw, input logic ill);
    return {19'd0, alu, ad, ga, sh, sl, in1, in2, rw, ill};
  endfunction

  task automatic present(input logic [31:0] instr, input logic [31:0] pc);
    in_instr = instr;
    in_pc    = pc;
    in_valid = 1'b1;
    @(posedge clock);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h002081B3;
    in_pc     = 32'h0000_1000;
    flush     = 1'b0;
    out_ready = 1'b1;

    // reset held across edges with in_valid high: nothing captured
    repeat (2) @(posedge clock);
    #1;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_pc", out_pc, 32'h0000_0100);
    chk("rst_imm", out_imm, 32'd0);
    chk("rst_ctrl", obs_ctrl(), 32'd0);
    chk("rst_rd", {27'd0, out_rd}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    @(negedge clock);
    rst_n = 1'b1;
    @(posedge clock);
    #1;
    chk("add_valid", {31'd0, out_valid}, 32'd1);
    chk("add_ctrl", obs_ctrl(), mk(2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0));
    chk("add_regs", {17'd0, out_rs1, out_rs2, out_rd}, {17'd0, 5'd1, 5'd2, 5'd3});
    chk("add_pc", out_pc, 32'h0000_1000);

    present(32'h402081B3, 32'h0000_1004);
    chk("sub_ctrl", obs_ctrl(), mk(2'b00, 1'b1, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0));
    chk("sub_pc", out_pc, 32'h0000_1004);

    present(32'h40335293, 32'h0000_1008);
    chk("srai_ctrl", obs_ctrl(), mk(2'b10, 1'b0, 2'b00, 2'b10, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0));
    chk("srai_imm", out_imm, 32'd3);
    chk("srai_regs", {17'd0, out_rs1, out_rs2, out_rd}, {17'd0, 5'd6, 5'd0, 5'd5});

    present(32'h42335293, 32'h0000_100C);
    chk("srai_bad", obs_ctrl(), mk(2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1));
    chk("srai_bad_valid", {31'd0, out_valid}, 32'd1);

    present(32'h123450B7, 32'h0000_1010);
    chk("lui_ctrl", obs_ctrl(), mk(2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 2'b10, 1'b1, 1'b1, 1'b0));
    chk("lui_imm", out_imm, 32'h12345000);

    present(32'hFE208EE3, 32'h0000_1014);
    chk("beq_ctrl", obs_ctrl(), mk(2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0));
    chk("beq_imm", out_imm, 32'hFFFFFFFC);

    present(32'h0020E233, 32'h0000_1018);
    chk("or_ctrl", obs_ctrl(), mk(2'b01, 1'b0, 2'b01, 2'b00, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0));

    present(32'hFFF0B393, 32'h0000_101C);
    chk("sltiu_ctrl", obs_ctrl(), mk(2'b11, 1'b0, 2'b00, 2'b00, 1'b1, 2'b00, 1'b1, 1'b1, 1'b0));
    chk("sltiu_imm", out_imm, 32'hFFFFFFFF);

    present(32'h00000013, 32'h0000_1020);
    chk("addi_x0_ctrl", obs_ctrl(), mk(2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0));

    present(32'h008000EF, 32'h0000_1024);
    chk("jal_ctrl", obs_ctrl(), mk(2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 2'b01, 1'b1, 1'b1, 1'b0));
    chk("jal_imm", out_imm, 32'd8);

    present(32'hFE20AC23, 32'h0000_1028);
    chk("sw_ctrl", obs_ctrl(), mk(2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0));
    chk("sw_imm", out_imm, 32'hFFFFFFF8);

    present(32'h0000007F, 32'h0000_102C);
    chk("opc7f_ctrl", obs_ctrl(), mk(2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1));

    present(32'h002081B0, 32'h0000_1030);
    chk("low2_ctrl", obs_ctrl(), mk(2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1));

    // drain, then backpressure
    in_valid = 1'b0;
    @(posedge clock);
    #1;
    chk("drain_valid", {31'd0, out_valid}, 32'd0);

    out_ready = 1'b0;
    present(32'h0020C233, 32'h0000_2000);
    chk("bp_a_valid", {31'd0, out_valid}, 32'd1);
    in_instr = 32'h0020E233;
    in_pc    = 32'h0000_2004;
    for (int k = 0; k < 5; k++) begin
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clock);
      #1;
      chk("bp_hold_pc", out_pc, 32'h0000_2000);
      chk("bp_hold_ctrl", obs_ctrl(), mk(2'b01, 1'b0, 2'b10, 2'b00, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0));
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clock);
    #1;
    chk("bp_b_valid", {31'd0, out_valid}, 32'd1);
    chk("bp_b_pc", out_pc, 32'h0000_2004);
    chk("bp_b_ctrl", obs_ctrl(), mk(2'b01, 1'b0, 2'b01, 2'b00, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0));
    in_valid = 1'b0;
    @(posedge clock);
    #1;
    chk("bp_empty", {31'd0, out_valid}, 32'd0);

    // flush with a simultaneous incoming instruction
    out_ready = 1'b0;
    present(32'h002081B3, 32'h0000_3000);
    chk("fl_full", {31'd0, out_valid}, 32'd1);
    flush = 1'b1;
    present(32'h402081B3, 32'h0000_3004);
    chk("fl_empty", {31'd0, out_valid}, 32'd0);
    flush    = 1'b0;
    in_valid = 1'b0;
    @(posedge clock);
    #1;
    chk("fl_dropped", {31'd0, out_valid}, 32'd0);

    // asynchronous reset while FULL
    present(32'h002081B3, 32'h0000_4000);
    in_valid = 1'b0;
    chk("ar_full", {31'd0, out_valid}, 32'd1);
    @(negedge clock);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", {31'd0, out_valid}, 32'd0);
    chk("ar_pc", out_pc, 32'h0000_0100);
    chk("ar_ctrl", obs_ctrl(), 32'd0);
    @(negedge clock);
    rst_n = 1'b1;
    @(posedge clock);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
